mem_write_checker: RTL and testbench
====================================

// Module: mem_write_checker
// PURPOSE
//  Synthesisable checker for the data-memory write bus of the computer.
//  Holds a table of up to DEPTH expected (address, data) writes.
//  Once armed, it watches memWrite/dataAddr/writeData and reports sticky pass/fail.
//  Sits beside dmem so both benches and FPGA builds can self-check a program run.
// PARAMETERS
//  N        32    data width (writeData, expected data)
//  A        32    address width (dataAddr, expected address)
//  DEPTH    8     number of expected-write entries; must be >= 1
//  TIMEOUT  1024  max ARMED cycles between consecutive matches before fail
// PORTS
//  clk          in   1                  system clock; all state updates on posedge
//  reset        in   1                  synchronous, active-high; clears all state including table count
//  exp_we       in   1                  load one expected entry (IDLE only)
//  exp_addr     in   A                  expected address for load
//  exp_data     in   N                  expected data for load
//  start        in   1                  arm checker
//  memWrite     in   1                  observed write strobe
//  dataAddr     in   A                  observed write address
//  writeData    in   N                  observed write data
//  busy         out  1                  1 while ARMED
//  pass         out  1                  sticky: all entries matched in order
//  fail         out  1                  sticky: check failed
//  fail_code    out  2                  00 none, 01 DATA_MISMATCH, 10 TIMEOUT, 11 UNEXPECTED
//  match_count  out  $clog2(DEPTH+1)    entries matched so far
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; load pointer and table count 0; timer 0.
//  FSM states are IDLE, ARMED, PASS and FAIL. All outputs are registered.
//  Loading:
//   - In IDLE, exp_we writes the entry at the load pointer, then pointer++.
//   - When count==DEPTH, further loads are ignored (saturate, no wrap).
//   - exp_we is ignored outside IDLE.
//  Start in IDLE:
//   - count>0: go to ARMED; idx=0, timer=0, match_count=0.
//   - count==0: start is ignored.
//   - If exp_we and start occur in the same cycle, start wins and the load is dropped.
//  ARMED, on a cycle with memWrite=1 and dataAddr==exp[idx].addr:
//   - writeData==exp[idx].data: idx++, match_count++, timer=0.
//     If this was entry count-1, go to PASS.
//   - writeData differs: go to FAIL with fail_code=01.
//  ARMED, on writes to any other address: see CONFIGURATION.
//  Timer:
//   - Increments on each ARMED cycle without a match.
//   - When timer reaches TIMEOUT-1 with no match that cycle: go to FAIL, fail_code=10.
//   - A match in the same cycle wins over timeout.
//  Latency: pass/fail assert on the clock edge after the deciding write is sampled.
//  PASS and FAIL are sticky.
//   - start in PASS/FAIL re-arms using the retained table and clears pass/fail/fail_code.
//   - Loading new entries requires reset.
//  start while ARMED: ignored.
//  reset in any state, including mid-ARMED: returns to reset values on that edge.
//  busy = (state==ARMED).
// CONFIGURATION
//  MWC_STRICT_EN defined:
//   - In ARMED, any memWrite with dataAddr != exp[idx].addr is a failure.
//   - The checker goes to FAIL with fail_code=11 (UNEXPECTED).
//  MWC_STRICT_EN undefined:
//   - Such writes are ignored and do not reset the timer.
//   - fail_code 11 is never produced.
// STRUCTURE
//  Package mwc_pkg:
//   - state_t enum {IDLE, ARMED, PASS, FAIL}.
//   - fail_code_t enum {FC_NONE=2'b00, FC_DATA=2'b01, FC_TIMEOUT=2'b10, FC_UNEXPECTED=2'b11}.
//   - Localparam IDX_W=$clog2(DEPTH+1).
//  Sub-module mwc_expect_table:
//   - DEPTH x (A+N) register array.
//   - Sync write port (we, wptr, addr, data); combinational read by idx; reset clears count only.
//  Top level: FSM, idx/match_count counters, timeout counter.
// TESTING
//  1. Load (84,0x96); start; write 84<-0x96 -> pass=1 next cycle, match_count=1, fail=0.
//  2. Load (84,0x96),(88,0x7); start; writes 84<-0x96, 88<-0x8 -> fail=1, fail_code=01, match_count=1.
//  3. TIMEOUT=16, one entry; start; no writes for 16 cycles -> fail=1, fail_code=10 exactly 16 cycles after start.
//  4. Two entries; interleave write 100<-0x1 before them:
//     - without MWC_STRICT_EN -> pass=1;
//     - with MWC_STRICT_EN -> fail_code=11.
//  5. Load DEPTH+2 entries -> only DEPTH retained; start with count 0 -> busy stays 0.
//     exp_we and start in the same cycle -> load dropped.
//  6. reset mid-ARMED after 1 match -> busy=0, match_count=0, count=0.
//     After PASS, start re-arms and the same sequence passes again.

Source files
------------

// File: rtl/mwc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mwc_pkg: shared state/fail-code types for mem_write_checker       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mwc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        PASS  = 2'b10,
        FAIL  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE       = 2'b00,
        FC_DATA       = 2'b01,
        FC_TIMEOUT    = 2'b10,
        FC_UNEXPECTED = 2'b11
    } fail_code_t;

    localparam int DEPTH_DEFAULT = 8;
    localparam int IDX_W         = $clog2(DEPTH_DEFAULT + 1);

    // Counter width able to hold 0..depth inclusive.
    function automatic int idx_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mwc_expect_table.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mwc_expect_table: DEPTH-entry (addr,data) table, append-only load |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mwc_expect_table
    import mwc_pkg::*;
#(
    parameter int N     = 32,
    parameter int A     = 32,
    parameter int DEPTH = 8,
    localparam int CW   = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [A-1:0]  addr,
    input  logic [N-1:0]  data,
    input  logic [CW-1:0] idx,
    output logic [A-1:0]  rd_addr,
    output logic [N-1:0]  rd_data,
    output logic [CW-1:0] count
);

    logic [A-1:0] tab_addr [DEPTH];
    logic [N-1:0] tab_data [DEPTH];
    logic         full;

    assign full = (count == CW'(DEPTH));

    // Load pointer is the entry count; it saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (we && !full) begin
            count <= count + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we && !full && (count == CW'(i))) begin
                tab_addr[i] <= addr;
                tab_data[i] <= data;
            end
        end
    end

    always_comb begin
        rd_addr = '0;
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx == CW'(i)) begin
                rd_addr = tab_addr[i];
                rd_data = tab_data[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_write_checker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_write_checker: in-order expected-write checker for dmem bus   |
// | Option MWC_STRICT_EN: off-sequence addresses fail as UNEXPECTED.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int N       = 32,
    parameter int A       = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024,
    localparam int CW     = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          exp_we,
    input  logic [A-1:0]  exp_addr,
    input  logic [N-1:0]  exp_data,
    input  logic          start,
    input  logic          memWrite,
    input  logic [A-1:0]  dataAddr,
    input  logic [N-1:0]  writeData,
    output logic          busy,
    output logic          pass,
    output logic          fail,
    output logic [1:0]    fail_code,
    output logic [CW-1:0] match_count
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t        state, state_n;
    fail_code_t    fc, fc_n;
    logic [CW-1:0] idx, idx_n, mc_n, count;
    logic [TW-1:0] timer, timer_n;
    logic [A-1:0]  cur_addr;
    logic [N-1:0]  cur_data;
    logic          tab_we, hit;

    // Loads only in IDLE; a simultaneous start takes precedence.
    assign tab_we    = exp_we && (state == IDLE) && !start;
    assign hit       = memWrite && (dataAddr == cur_addr);
    assign fail_code = fc;

    mwc_expect_table #(
        .N     (N),
        .A     (A),
        .DEPTH (DEPTH)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .we      (tab_we),
        .addr    (exp_addr),
        .data    (exp_data),
        .idx     (idx),
        .rd_addr (cur_addr),
        .rd_data (cur_data),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            match_count <= '0;
            timer       <= '0;
            fc          <= FC_NONE;
            busy        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            match_count <= mc_n;
            timer       <= timer_n;
            fc          <= fc_n;
            busy        <= (state_n == ARMED);
            pass        <= (state_n == PASS);
            fail        <= (state_n == FAIL);
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        mc_n    = match_count;
        timer_n = timer;
        fc_n    = fc;
        unique case (state)
            IDLE, PASS, FAIL: begin
                // Re-arm reuses the retained table; count is non-zero outside IDLE.
                if (start && (count != '0)) begin
                    state_n = ARMED;
                    idx_n   = '0;
                    mc_n    = '0;
                    timer_n = '0;
                    fc_n    = FC_NONE;
                end
            end
            ARMED: begin
                if (hit) begin
                    if (writeData == cur_data) begin
                        idx_n   = idx + CW'(1);
                        mc_n    = match_count + CW'(1);
                        timer_n = '0;
                        if (idx == (count - CW'(1))) begin
                            state_n = PASS;
                        end
                    end else begin
                        state_n = FAIL;
                        fc_n    = FC_DATA;
                    end
                end
`ifdef MWC_STRICT_EN
                else if (memWrite) begin
                    state_n = FAIL;
                    fc_n    = FC_UNEXPECTED;
                end
`endif
                else if (timer == TW'(TIMEOUT - 1)) begin
                    state_n = FAIL;
                    fc_n    = FC_TIMEOUT;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_write_checker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_write_checker: directed self-checking bench                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mem_write_checker;

    localparam int N       = 32;
    localparam int A       = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset, exp_we, start, memWrite;
    logic [A-1:0]  exp_addr, dataAddr;
    logic [N-1:0]  exp_data, writeData;
    logic          busy, pass, fail;
    logic [1:0]    fail_code;
    logic [CW-1:0] match_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_write_checker #(
        .N       (N),
        .A       (A),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .exp_we      (exp_we),
        .exp_addr    (exp_addr),
        .exp_data    (exp_data),
        .start       (start),
        .memWrite    (memWrite),
        .dataAddr    (dataAddr),
        .writeData   (writeData),
        .busy        (busy),
        .pass        (pass),
        .fail        (fail),
        .fail_code   (fail_code),
        .match_count (match_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input logic [A-1:0] a, input logic [N-1:0] d);
        exp_we   = 1'b1;
        exp_addr = a;
        exp_data = d;
        tick();
        exp_we   = 1'b0;
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic bus_write(input logic [A-1:0] a, input logic [N-1:0] d);
        memWrite  = 1'b1;
        dataAddr  = a;
        writeData = d;
        tick();
        memWrite  = 1'b0;
    endtask

    initial begin
        reset = 1'b0; exp_we = 1'b0; start = 1'b0; memWrite = 1'b0;
        exp_addr = '0; exp_data = '0; dataAddr = '0; writeData = '0;

        // Reset state
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail, 0);
        check("rst_fc",   fail_code, 0);
        check("rst_mc",   match_count, 0);

        // 1: single entry passes
        load(84, 32'h96);
        arm();
        check("t1_busy", busy, 1);
        bus_write(84, 32'h96);
        check("t1_pass", pass, 1);
        check("t1_mc",   match_count, 1);
        check("t1_fail", fail, 0);
        check("t1_busy_end", busy, 0);

        // 2: data mismatch on second entry
        do_reset();
        load(84, 32'h96);
        load(88, 32'h7);
        arm();
        bus_write(84, 32'h96);
        check("t2_mc_mid",   match_count, 1);
        check("t2_pass_mid", pass, 0);
        bus_write(88, 32'h8);
        check("t2_fail", fail, 1);
        check("t2_fc",   fail_code, 1);
        check("t2_mc",   match_count, 1);

        // 3: timeout exactly TIMEOUT cycles after the start edge
        do_reset();
        load(84, 32'h96);
        arm();
        for (int i = 1; i < TIMEOUT; i++) tick();
        check("t3_fail_early", fail, 0);
        check("t3_busy_early", busy, 1);
        tick();
        check("t3_fail", fail, 1);
        check("t3_fc",   fail_code, 2);
        check("t3_busy", busy, 0);

        // 4: interleaved off-sequence write
        do_reset();
        load(200, 32'h11);
        load(204, 32'h22);
        arm();
        bus_write(100, 32'h1);
`ifdef MWC_STRICT_EN
        check("t4_fail", fail, 1);
        check("t4_fc",   fail_code, 3);
`else
        check("t4_busy", busy, 1);
        check("t4_fail", fail, 0);
        bus_write(200, 32'h11);
        bus_write(204, 32'h22);
        check("t4_pass", pass, 1);
        check("t4_mc",   match_count, 2);
`endif

        // 5a: load+start together on empty table drops load; empty start ignored
        do_reset();
        exp_we = 1'b1; start = 1'b1; exp_addr = 300; exp_data = 32'h30;
        tick();
        exp_we = 1'b0; start = 1'b0;
        check("t5_busy_both", busy, 0);
        arm();
        check("t5_busy_empty", busy, 0);

        // 5b: DEPTH+2 loads saturate at DEPTH entries
        for (int i = 0; i < DEPTH + 2; i++) load(A'(i * 4), N'(i + 16));
        arm();
        check("t5_busy_arm", busy, 1);
        for (int i = 0; i < DEPTH; i++) bus_write(A'(i * 4), N'(i + 16));
        check("t5_pass", pass, 1);
        check("t5_mc",   match_count, DEPTH);

        // 5c: load coincident with start on non-empty table is dropped
        do_reset();
        load(300, 32'h30);
        exp_we = 1'b1; start = 1'b1; exp_addr = 304; exp_data = 32'h31;
        tick();
        exp_we = 1'b0; start = 1'b0;
        check("t5c_busy", busy, 1);
        bus_write(300, 32'h30);
        check("t5c_pass", pass, 1);

        // 6: reset mid-ARMED clears everything including the table
        do_reset();
        load(40, 32'hA);
        load(44, 32'hB);
        arm();
        bus_write(40, 32'hA);
        check("t6_mc_mid", match_count, 1);
        do_reset();
        check("t6_busy_rst", busy, 0);
        check("t6_mc_rst",   match_count, 0);
        arm();
        check("t6_busy_empty", busy, 0);

        // 6b: re-arm after PASS reuses table
        load(40, 32'hA);
        load(44, 32'hB);
        arm();
        bus_write(40, 32'hA);
        bus_write(44, 32'hB);
        check("t6_pass1", pass, 1);
        arm();
        check("t6_rearm_busy", busy, 1);
        check("t6_rearm_pass", pass, 0);
        check("t6_rearm_mc",   match_count, 0);
        bus_write(40, 32'hA);
        bus_write(44, 32'hB);
        check("t6_pass2", pass, 1);
        check("t6_mc2",   match_count, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
